ahbl_cmd_master: RTL and testbench

- AHB-Lite bus master sitting directly upstream of the team's AHB-Lite memory slaves (through the decoder/mux).
- Converts a simple valid/ready command stream (single read/write) into pipelined AHB-Lite NONSEQ transfers.
- Overlaps address phase N+1 with data phase N and returns one response per command, in order.
- Used by the TinyML accelerator DMA/control path to reach SRAM slaves.

---
 rtl/ahbl_pkg.sv | 45 ++++
 rtl/ahbl_cmd_master_if.sv | 45 ++++
 rtl/ahbl_cmd_master.sv | 130 +++++++++++++
 tb/tb_ahbl_cmd_master.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// ahbl_pkg: AHB-Lite transfer codes, pipeline stage bundles and the
// alignment/size legality helper shared by master, slaves and decoder.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic        write;
        logic [31:0] wdata;
    } a_stage_t;

    typedef struct packed {
        logic vld;
        logic err;
        logic write;
    } d_stage_t;

    // Only the two low address bits matter for alignment up to a word.
    function automatic logic ahbl_legal(input logic [1:0] addr_lo,
                                        input logic [2:0] size);
        logic ok;
        ok = 1'b0;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahbl_cmd_master_if.sv
// ahbl_cmd_master_if: command/response stream plus AHB-Lite master bus.
// master: the command master side; slave: command source + bus fabric.
interface ahbl_cmd_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    logic        bus_timeout;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  HREADY, HRDATA,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_err, rsp_rdata,
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output bus_timeout
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output HREADY, HRDATA,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  bus_timeout
    );

endinterface

// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: single read/write commands -> pipelined AHB-Lite NONSEQ.
// Ports: HCLK, HRESETn (async low), bus (ahbl_cmd_master_if.master).
module ahbl_cmd_master
    import ahbl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahbl_cmd_master_if.master bus
);

    a_stage_t         a_q, a_d;
    d_stage_t         d_q, d_d;
    logic [31:0]      haddr_q, haddr_d;
    htrans_e          htrans_q, htrans_d;
    logic [2:0]       hsize_q, hsize_d;
    logic             hwrite_q, hwrite_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_write_q, rsp_write_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             accept;
    logic             legal;

    assign bus.cmd_ready = bus.HREADY;
    assign accept        = bus.cmd_valid & bus.HREADY;
    assign legal         = ahbl_legal(bus.cmd_addr[1:0], bus.cmd_size);

    always_comb begin
        a_d         = a_q;
        d_d         = d_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;

        if (bus.HREADY) begin
            d_d.vld   = a_q.vld;
            d_d.err   = a_q.err;
            d_d.write = a_q.write;
            hwdata_d  = a_q.wdata;
            a_d       = '0;
            htrans_d  = HTRANS_IDLE;
            if (accept) begin
                a_d.vld   = 1'b1;
                a_d.err   = ~legal;
                a_d.write = bus.cmd_write;
                a_d.wdata = bus.cmd_wdata;
                // Illegal commands keep their slot but stay off the bus.
                if (legal) begin
                    haddr_d  = bus.cmd_addr;
                    htrans_d = HTRANS_NONSEQ;
                    hsize_d  = bus.cmd_size;
                    hwrite_d = bus.cmd_write;
                end
            end
            if (d_q.vld) begin
                rsp_valid_d = 1'b1;
                rsp_write_d = d_q.write;
                rsp_err_d   = d_q.err;
                if (!d_q.write && !d_q.err) begin
                    rsp_rdata_d = bus.HRDATA;
                end
            end
            cnt_d = '0;
        end else if (d_q.vld && cnt_q < CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (cnt_d == CNT_W'(TIMEOUT)) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_q         <= '0;
            d_q         <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            d_q         <= d_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.HADDR       = haddr_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HSIZE       = hsize_q;
    assign bus.HWRITE      = hwrite_q;
    assign bus.HWDATA      = hwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_write   = rsp_write_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.bus_timeout = tmo_q;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// tb_ahbl_cmd_master: directed + random commands against a memory slave
// and an in-order response model built from the command rules.
module tb_ahbl_cmd_master;
    import ahbl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ahbl_cmd_master_if bus();

    ahbl_cmd_master #(.TIMEOUT(16), .CNT_W(5)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        w;
        logic        e;
        logic [31:0] r;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [64] = '{default: '0};
    logic [31:0] slv_mem [64] = '{default: '0};
    int          checks    = 0;
    int          errors    = 0;
    int          rsp_cnt   = 0;
    int          n_pushed  = 0;
    int          n_flushed = 0;
    int          low_run   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [31:0] a,
                                          input logic [2:0]  s);
        logic [31:0] m;
        if (s == 3'd0)      m = 32'h0000_00FF << (8 * a[1:0]);
        else if (s == 3'd1) m = 32'h0000_FFFF << (8 * a[1:0]);
        else                m = 32'hFFFF_FFFF;
        return (old & ~m) | (d & m);
    endfunction

    function automatic bit legal_ref(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        return (a % (32'd1 << s)) == 32'd0;
    endfunction

    task automatic push_exp(input logic w, input logic [31:0] a,
                            input logic [2:0] s, input logic [31:0] d);
        exp_t x;
        x.w = w;
        x.e = !legal_ref(a, s);
        x.r = 32'h0;
        if (!x.e) begin
            if (w) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, a, s);
            else   x.r = ref_mem[a[7:2]];
        end
        exp_q.push_back(x);
        n_pushed++;
    endtask

    // Memory slave on the bus; HRDATA is valid for the current data phase.
    logic        dp_act;
    logic        dp_wr;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_act     <= 1'b0;
            dp_wr      <= 1'b0;
            dp_addr    <= '0;
            dp_size    <= '0;
            bus.HRDATA <= '0;
        end else if (bus.HREADY) begin
            if (dp_act && dp_wr)
                slv_mem[dp_addr[7:2]] <= merge(slv_mem[dp_addr[7:2]], bus.HWDATA, dp_addr, dp_size);
            dp_act  <= (bus.HTRANS == HTRANS_NONSEQ);
            dp_wr   <= bus.HWRITE;
            dp_addr <= bus.HADDR;
            dp_size <= bus.HSIZE;
            if (bus.HTRANS == HTRANS_NONSEQ && !bus.HWRITE) begin
                if (dp_act && dp_wr && dp_addr[7:2] == bus.HADDR[7:2])
                    bus.HRDATA <= merge(slv_mem[dp_addr[7:2]], bus.HWDATA, dp_addr, dp_size);
                else
                    bus.HRDATA <= slv_mem[bus.HADDR[7:2]];
            end else begin
                bus.HRDATA <= $urandom;
            end
        end
    end

    always @(negedge clk) begin : mon
        exp_t x;
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                chk("rsp_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                x = exp_q.pop_front();
                chk("rsp_write", {31'b0, bus.rsp_write}, {31'b0, x.w});
                chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, x.e});
                chk("rsp_rdata", bus.rsp_rdata, x.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = d;
        push_exp(w, a, s, d);
        tick();
    endtask

    task automatic rand_ready();
        if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
            bus.HREADY = 1'b1;
            low_run    = 0;
        end else begin
            bus.HREADY = 1'b0;
            low_run++;
        end
    endtask

    task automatic issue_rand();
        logic [31:0] a;
        logic [2:0]  s;
        logic        acc;
        s = 3'($urandom_range(0, 3));
        a = 32'h4000 | 32'($urandom_range(0, 255));
        if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << s) - 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = $urandom;
        push_exp(bus.cmd_write, a, s, bus.cmd_wdata);
        for (int n = 0; n < 8; n++) begin
            rand_ready();
            acc = bus.HREADY;
            tick();
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            rand_ready();
            tick();
        end
    endtask

    task automatic drain();
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b1;
        low_run       = 0;
        for (int n = 0; n < 12 && exp_q.size() != 0; n++) tick();
        tick();
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_haddr"}, bus.HADDR, 32'h0);
        chk({t, "_htrans"}, {30'b0, bus.HTRANS}, 32'h0);
        chk({t, "_hsize"}, {29'b0, bus.HSIZE}, 32'h0);
        chk({t, "_hwrite"}, {31'b0, bus.HWRITE}, 32'h0);
        chk({t, "_hwdata"}, bus.HWDATA, 32'h0);
        chk({t, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'h0);
        chk({t, "_rsp_write"}, {31'b0, bus.rsp_write}, 32'h0);
        chk({t, "_rsp_err"}, {31'b0, bus.rsp_err}, 32'h0);
        chk({t, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        chk({t, "_timeout"}, {31'b0, bus.bus_timeout}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b1;
        bus.HREADY    = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = '0;
        bus.cmd_wdata = '0;
        #1 rst_n = 1'b0;
        #2 check_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Write then read, zero wait states.
        send(1'b1, 32'h4000, 3'd2, 32'hDEAD_BEEF);
        chk("t1_htrans_w", {30'b0, bus.HTRANS}, 32'h2);
        chk("t1_haddr_w", bus.HADDR, 32'h4000);
        chk("t1_hwrite_w", {31'b0, bus.HWRITE}, 32'h1);
        send(1'b0, 32'h4000, 3'd2, 32'h0);
        chk("t1_htrans_r", {30'b0, bus.HTRANS}, 32'h2);
        chk("t1_hwrite_r", {31'b0, bus.HWRITE}, 32'h0);
        chk("t1_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        chk("t1_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
        bus.cmd_valid = 1'b0;
        tick();
        chk("t1_idle", {30'b0, bus.HTRANS}, 32'h0);
        chk("t1_rsp1_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("t1_rsp1_write", {31'b0, bus.rsp_write}, 32'h1);
        tick();
        chk("t1_rsp2_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("t1_rsp2_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t1_rsp_end", {31'b0, bus.rsp_valid}, 32'h0);

        // Back-to-back word reads.
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'h4000 + 32'(4 * i), 3'd2, 32'h0);
            chk("t2_haddr", bus.HADDR, 32'h4000 + 32'(4 * i));
            chk("t2_htrans", {30'b0, bus.HTRANS}, 32'h2);
            if (i >= 2) chk("t2_rsp", {31'b0, bus.rsp_valid}, 32'h1);
        end
        bus.cmd_valid = 1'b0;
        tick();
        chk("t2_rsp", {31'b0, bus.rsp_valid}, 32'h1);
        tick();
        chk("t2_rsp", {31'b0, bus.rsp_valid}, 32'h1);
        tick();
        chk("t2_rsp_end", {31'b0, bus.rsp_valid}, 32'h0);

        // Wait states during a write data phase.
        send(1'b1, 32'h4010, 3'd2, 32'h1357_9BDF);
        send(1'b0, 32'h4010, 3'd2, 32'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h4004;
        bus.cmd_size  = 3'd2;
        push_exp(1'b0, 32'h4004, 3'd2, 32'h0);
        bus.HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
            chk("t3_haddr", bus.HADDR, 32'h4010);
            chk("t3_htrans", {30'b0, bus.HTRANS}, 32'h2);
            chk("t3_hwrite", {31'b0, bus.HWRITE}, 32'h0);
            chk("t3_hwdata", bus.HWDATA, 32'h1357_9BDF);
            chk("t3_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
            tick();
        end
        bus.HREADY = 1'b1;
        chk("t3_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t3_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("t3_rsp_write", {31'b0, bus.rsp_write}, 32'h1);
        chk("t3_haddr_next", bus.HADDR, 32'h4004);
        drain();

        // Illegal commands between legal neighbours.
        send(1'b1, 32'h4020, 3'd2, 32'hA5A5_1234);
        chk("t4_htrans0", {30'b0, bus.HTRANS}, 32'h2);
        send(1'b0, 32'h4001, 3'd1, $urandom);
        chk("t4_htrans1", {30'b0, bus.HTRANS}, 32'h0);
        send(1'b0, 32'h4024, 3'd3, $urandom);
        chk("t4_htrans2", {30'b0, bus.HTRANS}, 32'h0);
        send(1'b0, 32'h4020, 3'd2, 32'h0);
        chk("t4_htrans3", {30'b0, bus.HTRANS}, 32'h2);
        chk("t4_haddr3", bus.HADDR, 32'h4020);
        drain();

        // Randomized traffic with short wait-state bursts.
        for (int c = 0; c < 60; c++) issue_rand();
        drain();

        // Timeout on a 16-cycle stall.
        chk("t5_timeout_pre", {31'b0, bus.bus_timeout}, 32'h0);
        send(1'b0, 32'h4000, 3'd2, 32'h0);
        bus.cmd_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t5_timeout", {31'b0, bus.bus_timeout}, (k == 16) ? 32'h1 : 32'h0);
        end
        bus.HREADY = 1'b1;
        tick();
        chk("t5_rsp", {31'b0, bus.rsp_valid}, 32'h1);
        chk("t5_timeout_sticky", {31'b0, bus.bus_timeout}, 32'h1);
        tick();
        chk("t5_timeout_sticky", {31'b0, bus.bus_timeout}, 32'h1);
        drain();

        // Reset in the middle of a stalled data phase.
        send(1'b0, 32'h4004, 3'd2, 32'h0);
        send(1'b0, 32'h4008, 3'd2, 32'h0);
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset("t6");
        n_flushed += exp_q.size();
        exp_q.delete();
        bus.HREADY = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_flush", {31'b0, bus.rsp_valid}, 32'h0);
        end
        send(1'b1, 32'h4030, 3'd2, 32'hCAFE_F00D);
        chk("t6_htrans", {30'b0, bus.HTRANS}, 32'h2);
        send(1'b0, 32'h4030, 3'd2, 32'h0);
        drain();

        chk("rsp_count", 32'(rsp_cnt), 32'(n_pushed - n_flushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
